// File: rtl/train_sequencer_if.sv
// train_sequencer_if
//   Sample stream between the host/sample buffer and the training controller.
//   One sample is an (x1, x2, target) triple of 32-bit words. A sample moves
//   on a rising clock edge where s_valid and s_ready are both high.
//   Signals:
//     s_valid   source -> sink   sample available
//     s_ready   sink -> source   sink accepts a sample
//     s_x1      source -> sink   sample input 1
//     s_x2      source -> sink   sample input 2
//     s_target  source -> sink   sample target
//   Modports: master = sample source, slave = controller.
interface train_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_x1;
    logic [31:0] s_x2;
    logic [31:0] s_target;

    modport master (output s_valid, s_x1, s_x2, s_target, input s_ready);
    modport slave  (input s_valid, s_x1, s_x2, s_target, output s_ready);
endinterface

// File: rtl/train_sequencer.sv
// train_sequencer
//   Training-loop controller for the 2-3-1 perceptron. It pulls samples from
//   the sample stream, holds them on the network inputs, waits the forward and
//   backward latencies, issues one weight-update pulse per sample and counts
//   samples and epochs until the configured number of epochs is complete.
//   Optional build macro: FETCH_TIMEOUT_EN adds a FETCH wait limit of TIMEOUT
//   cycles that raises timeout_err; without it timeout_err is constant 0.
//   Ports:
//     clk, reset         clock (rising edge), asynchronous active-high reset
//     start, abort       begin training (IDLE only), synchronous cancel
//     num_samples        samples per epoch, latched at start
//     num_epochs         epoch count, latched at start
//     step_in            learning rate, latched at start
//     smp                sample stream (slave side)
//     net_a/b/target     held sample presented to the network
//     net_step           held learning rate
//     net_update         one-cycle weight-update enable
//     busy, done         not-IDLE flag, one-cycle completion pulse
//     aborted            sticky abort flag, timeout_err sticky timeout flag
//     sample_cnt         index of the current sample within the epoch
//     epoch_cnt          index of the current epoch
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | s_ready high, waiting for a sample
//   FWD    | forward pass settling
//   BWD    | backward pass settling
//   UPDATE | net_update high, weights commit
//   NEXT   | advance sample/epoch counters
//   DONE   | training complete, done pulses next cycle
module train_sequencer #(
    parameter int LAT_FWD = 3,
    parameter int LAT_BWD = 1,
    parameter int CNT_W   = 8,
    parameter int EPOCH_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic [EPOCH_W-1:0] num_epochs,
    input  logic [31:0]        step_in,
    train_sequencer_if.slave   smp,
    output logic [31:0]        net_a,
    output logic [31:0]        net_b,
    output logic [31:0]        net_target,
    output logic [31:0]        net_step,
    output logic               net_update,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [EPOCH_W-1:0] epoch_cnt
);

    typedef enum logic [2:0] {IDLE, FETCH, FWD, BWD, UPDATE, NEXT, DONE} state_t;

    localparam int LAT_MAX = (LAT_FWD > LAT_BWD) ? LAT_FWD : LAT_BWD;
    localparam int WAIT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    state_t             state, next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   num_samples_q;
    logic [EPOCH_W-1:0] num_epochs_q;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               start_ok;
    logic               last_sample;
    logic               fetch_tmo;

    assign start_ok    = start && (num_samples != '0) && (num_epochs != '0);
    assign last_sample = (sample_cnt == num_samples_q - CNT_W'(1));
    assign epoch_inc   = epoch_cnt + EPOCH_W'(1);
    assign smp.s_ready = (state == FETCH);

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts FETCH cycles without a sample; zero whenever outside FETCH, so
    // every FETCH entry starts a fresh wait.
    assign fetch_tmo = (state == FETCH) && !smp.s_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != FETCH)
                tmo_cnt <= '0;
            else if (!smp.s_valid)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == IDLE && start_ok)
                timeout_err <= 1'b0;
            else if (fetch_tmo && !abort)
                timeout_err <= 1'b1;
        end
    end
`else
    assign fetch_tmo   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_ok) next_state = FETCH;
            FETCH: begin
                if (smp.s_valid)
                    next_state = FWD;
                else if (fetch_tmo)
                    next_state = IDLE;
            end
            FWD:     if (wait_cnt == '0) next_state = BWD;
            BWD:     if (wait_cnt == '0) next_state = UPDATE;
            UPDATE:  next_state = NEXT;
            NEXT:    next_state = (last_sample && epoch_inc == num_epochs_q) ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // abort wins over every other transition
        if (abort && state != IDLE)
            next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt      <= '0;
            num_samples_q <= '0;
            num_epochs_q  <= '0;
            net_a         <= '0;
            net_b         <= '0;
            net_target    <= '0;
            net_step      <= '0;
            net_update    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            sample_cnt    <= '0;
            epoch_cnt     <= '0;
        end else begin
            done       <= 1'b0;
            // registered so the pulse spans a whole cycle, including the
            // falling edge on which the datapath commits weights
            net_update <= (next_state == UPDATE);
            busy       <= (next_state != IDLE);
            if (abort && state != IDLE)
                aborted <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        num_samples_q <= num_samples;
                        num_epochs_q  <= num_epochs;
                        net_step      <= step_in;
                        sample_cnt    <= '0;
                        epoch_cnt     <= '0;
                        aborted       <= 1'b0;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                FETCH: begin
                    if (next_state == FWD) begin
                        net_a      <= smp.s_x1;
                        net_b      <= smp.s_x2;
                        net_target <= smp.s_target;
                        wait_cnt   <= WAIT_W'(LAT_FWD - 1);
                    end
                end
                FWD: begin
                    if (wait_cnt == '0)
                        wait_cnt <= WAIT_W'(LAT_BWD - 1);
                    else
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                BWD: begin
                    if (wait_cnt != '0)
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                NEXT: begin
                    if (next_state != IDLE) begin
                        if (last_sample) begin
                            sample_cnt <= '0;
                            epoch_cnt  <= epoch_inc;
                        end else begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!abort)
                        done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;
    localparam int CNT_W   = 8;
    localparam int EPOCH_W = 16;
    localparam int LAT_FWD = 3;
    localparam int LAT_BWD = 1;
    localparam int TIMEOUT = 255;
    localparam int LAT     = LAT_FWD + LAT_BWD;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        logic [31:0] st;
        int          smp;
        int          ep;
        int          cyc;
    } upd_t;

    typedef struct {
        int cyc;
        int ep;
        int smp;
    } done_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic [EPOCH_W-1:0] num_epochs = '0;
    logic [31:0]        step_in = '0;
    logic [31:0]        net_a, net_b, net_target, net_step;
    logic               net_update, busy, done, aborted, timeout_err;
    logic [CNT_W-1:0]   sample_cnt;
    logic [EPOCH_W-1:0] epoch_cnt;

    train_sequencer_if sif();

    train_sequencer #(
        .LAT_FWD(LAT_FWD), .LAT_BWD(LAT_BWD), .CNT_W(CNT_W),
        .EPOCH_W(EPOCH_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_samples(num_samples), .num_epochs(num_epochs), .step_in(step_in),
        .smp(sif.slave),
        .net_a(net_a), .net_b(net_b), .net_target(net_target), .net_step(net_step),
        .net_update(net_update), .busy(busy), .done(done), .aborted(aborted),
        .timeout_err(timeout_err), .sample_cnt(sample_cnt), .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_fail = 0;
    upd_t  upd_q[$];
    done_t done_q[$];
    int    upd_log[$];
    int    upd_seen = 0;
    int    done_seen = 0;
    int    last_done_cyc = 0;
    int    start_edge = 0;

    // reference model state
    bit          model_en = 1'b0;
    int          run_n = 1;
    int          run_e = 1;
    int          n_hs = 0;
    logic [31:0] step_exp = '0;
    int          drv_mode = 0;   // 0 manual, 1 valid always, 2 valid random

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_net_a"}, 64'(net_a), 64'd0);
        check({tag, "_net_b"}, 64'(net_b), 64'd0);
        check({tag, "_net_target"}, 64'(net_target), 64'd0);
        check({tag, "_net_step"}, 64'(net_step), 64'd0);
        check({tag, "_net_update"}, 64'(net_update), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_aborted"}, 64'(aborted), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_s_ready"}, 64'(sif.s_ready), 64'd0);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_epoch_cnt"}, 64'(epoch_cnt), 64'd0);
    endtask

    // Stream driver: new random sample after every accepted one.
    bit hs_d;
    always begin
        @(negedge clk);
        hs_d = sif.s_valid && sif.s_ready;
        @(posedge clk);
        #1;
        if (drv_mode != 0) begin
            if (hs_d) begin
                sif.s_x1     = $urandom;
                sif.s_x2     = $urandom;
                sif.s_target = $urandom;
            end
            sif.s_valid = (drv_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Reference model: every accepted sample owes one update LAT cycles after
    // its handshake edge; the last sample of the last epoch owes a done pulse
    // three cycles after its update.
    upd_t mu;
    always @(negedge clk) begin
        if (model_en && sif.s_valid && sif.s_ready) begin
            mu.a   = sif.s_x1;
            mu.b   = sif.s_x2;
            mu.t   = sif.s_target;
            mu.st  = step_exp;
            mu.smp = n_hs % run_n;
            mu.ep  = n_hs / run_n;
            mu.cyc = cyc + 1 + LAT;
            upd_q.push_back(mu);
            n_hs++;
            if (n_hs == run_n * run_e)
                done_q.push_back('{cyc + 1 + LAT + 3, run_e, 0});
        end
    end

    // Monitor: pops expectations whenever the DUT presents an update or done.
    upd_t  ue;
    done_t de;
    always @(negedge clk) begin
        if (net_update === 1'b1) begin
            upd_seen++;
            upd_log.push_back(cyc);
            if (upd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_update: net_update=1 at cycle %0d, required 0", cyc);
            end else begin
                ue = upd_q.pop_front();
                check("upd_cycle", 64'(cyc), 64'(ue.cyc));
                check("upd_net_a", 64'(net_a), 64'(ue.a));
                check("upd_net_b", 64'(net_b), 64'(ue.b));
                check("upd_net_target", 64'(net_target), 64'(ue.t));
                check("upd_net_step", 64'(net_step), 64'(ue.st));
                check("upd_sample_cnt", 64'(sample_cnt), 64'(ue.smp));
                check("upd_epoch_cnt", 64'(epoch_cnt), 64'(ue.ep));
                check("upd_busy", 64'(busy), 64'd1);
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
            end else begin
                de = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(de.cyc));
                check("done_busy", 64'(busy), 64'd0);
                if (de.ep >= 0) begin
                    check("done_epoch_cnt", 64'(epoch_cnt), 64'(de.ep));
                    check("done_sample_cnt", 64'(sample_cnt), 64'(de.smp));
                end
            end
        end
    end

    task automatic start_run(input int n, input int e, input logic [31:0] st);
        @(posedge clk);
        #1;
        num_samples = CNT_W'(n);
        num_epochs  = EPOCH_W'(e);
        step_in     = st;
        step_exp    = st;
        run_n       = (n == 0) ? 1 : n;
        run_e       = e;
        n_hs        = 0;
        model_en    = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        step_in    = $urandom;
        start_edge = cyc;
        if (n == 0 || e == 0) begin
            done_q.push_back('{cyc, -1, -1});
            @(negedge clk);
            check("zero_start_busy", 64'(busy), 64'd0);
        end else begin
            @(negedge clk);
            check("start_busy", 64'(busy), 64'd1);
            check("start_aborted", 64'(aborted), 64'd0);
            check("start_timeout_err", 64'(timeout_err), 64'd0);
            check("start_sample_cnt", 64'(sample_cnt), 64'd0);
            check("start_epoch_cnt", 64'(epoch_cnt), 64'd0);
            check("start_s_ready", 64'(sif.s_ready), 64'd1);
        end
    endtask

    task automatic wait_done(input int d0, input int maxc);
        int k = 0;
        while (done_seen == d0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (done_seen == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, required one pulse", maxc);
        end
        @(negedge clk);
    endtask

    task automatic stop_driver();
        @(negedge clk);
        drv_mode    = 0;
        sif.s_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int u0;
        int k;
        sif.s_valid  = 1'b0;
        sif.s_x1     = '0;
        sif.s_x2     = '0;
        sif.s_target = '0;

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // zero counts: done only
        d0 = done_seen;
        start_run(0, 3, 32'h1234_5678);
        wait_done(d0, 5);
        d0 = done_seen;
        start_run(2, 0, 32'h1234_5678);
        wait_done(d0, 5);
        check("zero_net_step", 64'(net_step), 64'd0);

        // 4 samples x 2 epochs, s_valid constantly high
        drv_mode = 1;
        upd_log.delete();
        d0 = done_seen;
        start_run(4, 2, 32'h3DCC_CCCD);
        wait_done(d0, 200);
        check("run1_updates", 64'(upd_log.size()), 64'd8);
        for (int i = 0; i < upd_log.size() && i < 8; i++)
            check("run1_update_time", 64'(upd_log[i] - start_edge), 64'(5 + 7 * i));
        check("run1_done_time", 64'(last_done_cyc - start_edge), 64'd57);
        check("run1_epoch_end", 64'(epoch_cnt), 64'd2);
        check("run1_sample_end", 64'(sample_cnt), 64'd0);
        stop_driver();

        // late sample with fixed values
        d0 = done_seen;
        start_run(1, 1, 32'h3C23_D70A);
        repeat (10) @(negedge clk);
        check("late_s_ready", 64'(sif.s_ready), 64'd1);
        check("late_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        sif.s_x1     = 32'h3F80_0000;
        sif.s_x2     = 32'h4000_0000;
        sif.s_target = 32'h3F00_0000;
        sif.s_valid  = 1'b1;
        @(posedge clk);
        #1;
        sif.s_valid  = 1'b0;
        sif.s_x1     = $urandom;
        sif.s_x2     = $urandom;
        sif.s_target = $urandom;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            check("late_hold_a", 64'(net_a), 64'h3F80_0000);
            check("late_hold_b", 64'(net_b), 64'h4000_0000);
            check("late_hold_t", 64'(net_target), 64'h3F00_0000);
            check("late_update_pos", 64'(net_update), (i == 4) ? 64'd1 : 64'd0);
        end
        wait_done(d0, 20);

        // randomized runs with random s_valid gaps
        for (int r = 0; r < 5; r++) begin
            drv_mode = 2;
            d0 = done_seen;
            start_run($urandom_range(1, 5), $urandom_range(1, 3), $urandom);
            wait_done(d0, 2000);
            stop_driver();
        end

        // abort in FWD of sample 2
        drv_mode = 1;
        d0 = done_seen;
        start_run(4, 1, 32'h0000_0042);
        k = 0;
        while (n_hs < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_sample2", 64'(n_hs), 64'd3);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_aborted", 64'(aborted), 64'd1);
        check("abort_s_ready", 64'(sif.s_ready), 64'd0);
        check("abort_sample_cnt", 64'(sample_cnt), 64'd2);
        check("abort_net_update", 64'(net_update), 64'd0);
        check("abort_pending_upd", 64'(upd_q.size()), 64'd1);
        if (upd_q.size() > 0)
            check("abort_net_a_hold", 64'(net_a), 64'(upd_q[0].a));
        upd_q.delete();
        model_en = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'(d0));
        check("abort_sticky", 64'(aborted), 64'd1);
        d0 = done_seen;
        start_run(2, 1, 32'h0000_0043);
        wait_done(d0, 100);
        stop_driver();

        // asynchronous reset in BWD
        drv_mode = 1;
        start_run(2, 1, 32'h0000_0099);
        k = 0;
        @(negedge clk);
        while (!(sif.s_valid && sif.s_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #2;
        model_en = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        upd_q.delete();
        done_q.delete();
        drv_mode = 0;
        sif.s_valid = 1'b0;
        u0 = upd_seen;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("reset_no_update", 64'(upd_seen), 64'(u0));
        check("reset_idle_busy", 64'(busy), 64'd0);

        // FETCH with no samples
        d0 = done_seen;
        start_run(1, 1, 32'h0000_0007);
`ifdef FETCH_TIMEOUT_EN
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        check("tmo_before_busy", 64'(busy), 64'd1);
        check("tmo_before_err", 64'(timeout_err), 64'd0);
        @(negedge clk);
        check("tmo_err", 64'(timeout_err), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_s_ready", 64'(sif.s_ready), 64'd0);
        repeat (5) @(negedge clk);
        check("tmo_no_done", 64'(done_seen), 64'(d0));
`else
        repeat (300) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_s_ready", 64'(sif.s_ready), 64'd1);
        check("wait_timeout_err", 64'(timeout_err), 64'd0);
        check("wait_no_done", 64'(done_seen), 64'(d0));
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("wait_abort_busy", 64'(busy), 64'd0);
        check("wait_abort_flag", 64'(aborted), 64'd1);
`endif
        model_en = 1'b0;
        repeat (3) @(negedge clk);
        check("final_upd_q_empty", 64'(upd_q.size()), 64'd0);
        check("final_done_q_empty", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Training-loop controller for the 2-3-1 perceptron (input register layer, 3-neuron hidden layer, backprop output neuron).
- Pulls (x1, x2, target) samples from a valid/ready stream, holds them on the network inputs, and waits the forward and backward latencies.
- Issues exactly one weight-update pulse per sample, then counts samples and epochs and signals completion.
- Sits between the host/sample buffer and the network datapath.

Parameters:
- LAT_FWD, 3, cycles from sample latch to a settled network output.
- LAT_BWD, 1, cycles from settled output to settled delta/new-weight values.
- CNT_W, 8, width of the sample counter.
- EPOCH_W, 16, width of the epoch counter.
- TIMEOUT, 255, FETCH wait limit in cycles; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; the controller updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin training; sampled in IDLE only.
- abort  in  1  synchronous cancel.
- num_samples  in  CNT_W  samples per epoch; latched at start.
- num_epochs  in  EPOCH_W  epoch count; latched at start.
- step_in  in  32  learning rate; latched at start.
- s_valid  in  1  sample available.
- s_ready  out  1  controller accepts a sample.
- s_x1  in  32  sample input 1.
- s_x2  in  32  sample input 2.
- s_target  in  32  sample target.
- net_a  out  32  held network input 1.
- net_b  out  32  held network input 2.
- net_target  out  32  held target.
- net_step  out  32  held learning rate.
- net_update  out  1  weight-update enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  sticky; cleared by an accepted start.
- timeout_err  out  1  sticky; cleared by an accepted start.
- sample_cnt  out  CNT_W  index of the current sample.
- epoch_cnt  out  EPOCH_W  index of the current epoch.

Behaviour:
- Reset: state IDLE; every output and register is 0.
- All outputs are registered, except s_ready, which is decoded from state (FETCH).
- States: IDLE, FETCH, FWD, BWD, UPDATE, NEXT, DONE.
- IDLE:
  - start=1 with num_samples≠0 and num_epochs≠0: latch num_samples, num_epochs and step_in; clear both counters, aborted and timeout_err; go to FETCH.
  - start=1 with either count 0: done pulses the next cycle; stay in IDLE.
- FETCH:
  - s_ready=1.
  - On s_valid&s_ready: latch s_x1, s_x2 and s_target into net_a, net_b and net_target; load the wait counter with LAT_FWD-1; go to FWD.
  - net_* values hold until the next handshake.
- FWD: decrement the wait counter; at 0, load LAT_BWD-1 and go to BWD.
- BWD: decrement; at 0, go to UPDATE.
- UPDATE: net_update=1 for exactly one cycle. Because it is registered on the rising edge, it covers one full falling edge, where the datapath commits new weights.
- NEXT:
  - If sample_cnt==num_samples-1: sample_cnt←0 and epoch_cnt+1. Then, if the new epoch_cnt equals num_epochs, go to DONE; otherwise go to FETCH.
  - Otherwise: sample_cnt+1, go to FETCH.
- DONE: done=1 for one cycle; go to IDLE. The counters keep their final values (epoch_cnt=num_epochs).
- Per-sample cost with immediate s_valid: LAT_FWD+LAT_BWD+3 cycles (7 at default parameters).
- Handshake latched at edge E0 → net_update high in the cycle starting at edge E0+LAT_FWD+LAT_BWD.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and aborted←1.
  - net_update is forced to 0 in that same cycle.
  - done is not pulsed; counters freeze; net_* values hold.
  - abort has priority over every other transition.
- start while busy is ignored.
- Asynchronous reset mid-operation returns to the reset values immediately; no update pulse is emitted.
- Counters wrap modulo 2^width only on misconfiguration; num_samples and num_epochs are at most 2^width-1 by type.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A cycle counter runs while in FETCH with s_valid=0 and clears on each FETCH entry.
  - Reaching TIMEOUT → timeout_err←1, go to IDLE, no done pulse.
- FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Reset, then idle: all outputs 0, s_ready=0, busy=0; start with num_samples=0 → done pulse one cycle later, busy stays 0.
- num_samples=4, num_epochs=2, s_valid constantly 1, start at edge 0:
  - net_update pulses exactly 8 times, 7 cycles apart.
  - done is high in the cycle starting at edge 57.
  - epoch_cnt=2 and sample_cnt=0 at the end.
- s_valid held low for 10 cycles in FETCH, then one sample x1=0x3F800000, x2=0x40000000, target=0x3F000000: net_a, net_b and net_target take those values at the handshake edge and hold them through UPDATE; net_update rises 4 cycles after the handshake.
- abort asserted in the FWD state of sample 2: IDLE next cycle, aborted=1, no net_update and no done; a following start clears aborted and restarts at sample_cnt=0.
- Asynchronous reset asserted mid-BWD (between clock edges): outputs go to 0 immediately; no net_update afterwards.
- With FETCH_TIMEOUT_EN and TIMEOUT=255, s_valid held 0: after 255 FETCH cycles, timeout_err=1, busy=0, done never pulses.
